uart_rx_sequencer: RTL

Sequences reception of one serial UART frame: start, WIDTH data bits LSB-first, one stop bit.
- Synchronizes the raw line and qualifies the start bit at mid-bit.
- Counts oversample ticks from the baud unit and samples each data bit at bit centre.
- Delivers the byte through a one-entry holding buffer with valid/ready handshake.
- Sits between the baud unit (source of sample_tick) and the byte consumer; replaces ad-hoc start/hold_value sequencing of the receive path.

---
 rtl/uart_rx_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start qualification, mid-bit data sampling,
// stop check and a one-entry valid/ready holding buffer.
module uart_rx_sequencer #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             rx_line,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_rx_s;
  logic [TW-1:0]    r_tick_cnt;
  logic [TW-1:0]    w_tick_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_done;
  logic             w_ferr;
  logic             w_mid;
  logic             w_end;

  assign w_mid = (r_tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign w_end = (r_tick_cnt == TW'(OVERSAMPLE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    if (sample_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (w_mid) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (w_end) begin
            w_shift_nxt = {r_rx_s, r_shift[WIDTH-1:1]};
            w_bit_nxt   = r_bit_cnt + BW'(1);
            w_tick_nxt  = '0;
            if (r_bit_cnt == BW'(WIDTH - 1))
              w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        S_STOP: begin
          if (w_end) begin
            w_tick_nxt = '0;
            if (r_rx_s) begin
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        S_BREAK: begin
          // A held-low line stays here so it cannot look like a new start.
          if (r_rx_s)
            w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync1    <= rx_line;
      r_rx_s     <= r_sync1;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_ferr     <= w_ferr;
      r_ovr      <= 1'b0;
      if (w_done) begin
        if (!r_valid || out_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != S_IDLE);

endmodule
